// File: rtl/fft_pkg.sv
// Shared definitions for the complex divider: FSM states and default
// fixed-point format constants.
package fft_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_PREP = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int WORD_SIZE = 16;
  localparam int FRAC      = WORD_SIZE - 1;

  localparam logic [WORD_SIZE-1:0] SAT_MAX = {1'b0, {FRAC{1'b1}}};
  localparam logic [WORD_SIZE-1:0] SAT_MIN = {1'b1, {FRAC{1'b0}}};

endpackage

// File: rtl/cdiv_udiv_iter.sv
// Unsigned restoring divider, one quotient bit per step. The dividend is
// assumed smaller than the divisor, so the quotient is a pure fraction.
module udiv_iter #(
  parameter int dw = 32,
  parameter int qw = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [dw-1:0] dividend,
  input  logic [dw-1:0] divisor,
  output logic [qw-1:0] quotient,
  output logic [qw-1:0] quotient_next
);

  logic [dw-1:0] rem;
  logic [dw:0]   trial;
  logic [dw:0]   diff;
  logic          take;

  always_comb begin
    trial         = {rem, 1'b0};
    take          = (trial >= {1'b0, divisor});
    diff          = trial - {1'b0, divisor};
    quotient_next = {quotient[qw-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      quotient <= '0;
    end else if (load) begin
      rem      <= dividend;
      quotient <= '0;
    end else if (step) begin
      rem      <= take ? diff[dw-1:0] : trial[dw-1:0];
      quotient <= quotient_next;
    end
  end

endmodule

// File: rtl/cdiv.sv
// Complex fixed-point divider C = A*conj(B)/|B|^2 with valid/ready handshake,
// saturation and divide-by-zero flags.
module cdiv
  import fft_pkg::*;
#(
  parameter int word_size = WORD_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*word_size-1:0] A,
  input  logic [2*word_size-1:0] B,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2*word_size-1:0] C,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_ovf,
  output logic                   out_dz
);

  localparam int w  = word_size;
  localparam int pw = 2 * word_size;
  localparam int nw = 2 * word_size + 1;
  localparam int qw = word_size - 1;
  localparam int cw = $clog2(word_size);

  localparam logic [w-1:0]  sat_pos   = {1'b0, {qw{1'b1}}};
  localparam logic [w-1:0]  sat_neg   = {1'b1, {qw{1'b0}}};
  localparam logic [cw-1:0] cnt_start = cw'(word_size - 1);

  state_t state, state_next;

  logic [pw-1:0]        a_r, b_r;
  logic signed [pw-1:0] p_rr, p_ii, p_ir, p_ri, p_br2, p_bi2;
  logic [pw-1:0]        d_r;
  logic                 neg_r, neg_i, sat_r, sat_i, dz_r;
  logic [cw-1:0]        cnt;
  logic                 load, step, last;

  logic signed [w-1:0]  ar, ai, br, bi;
  logic signed [nw-1:0] nr_c, ni_c;
  logic [nw-1:0]        mag_r, mag_i;
  logic [pw-1:0]        d_c;
  logic                 dz_c, sat_r_c, sat_i_c;
  logic [pw-1:0]        dvd_r, dvd_i;
  logic [qw-1:0]        q_r, q_i, qn_r, qn_i;
  logic [w-1:0]         res_r, res_i;

  function automatic logic [w-1:0] finish_comp(input logic neg, input logic sat,
                                               input logic dz, input logic [qw-1:0] q);
    logic [w-1:0] mag;
    mag = {1'b0, q};
    if (dz)       return sat_pos;
    else if (sat) return neg ? sat_neg : sat_pos;
    else          return neg ? (~mag + 1'b1) : mag;
  endfunction

  always_comb begin
    ar      = a_r[pw-1:w];
    ai      = a_r[w-1:0];
    br      = b_r[pw-1:w];
    bi      = b_r[w-1:0];
    nr_c    = {p_rr[pw-1], p_rr} + {p_ii[pw-1], p_ii};
    ni_c    = {p_ir[pw-1], p_ir} - {p_ri[pw-1], p_ri};
    mag_r   = nr_c[nw-1] ? (~nr_c + 1'b1) : nr_c;
    mag_i   = ni_c[nw-1] ? (~ni_c + 1'b1) : ni_c;
    d_c     = $unsigned(p_br2) + $unsigned(p_bi2);
    dz_c    = (d_c == '0);
    sat_r_c = !dz_c && (mag_r >= {1'b0, d_c});
    sat_i_c = !dz_c && (mag_i >= {1'b0, d_c});
    // Out-of-range operands never reach the dividers; their result is a constant
    dvd_r   = (dz_c || sat_r_c) ? '0 : mag_r[pw-1:0];
    dvd_i   = (dz_c || sat_i_c) ? '0 : mag_i[pw-1:0];
    last    = (state == S_DIV) && (cnt == cw'(1));
    res_r   = finish_comp(neg_r, sat_r, dz_r, qn_r);
    res_i   = finish_comp(neg_i, sat_i, dz_r, qn_i);
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_MUL;
      end
      S_MUL:  state_next = S_PREP;
      S_PREP: begin
        load       = 1'b1;
        state_next = S_DIV;
      end
      S_DIV: begin
        step = 1'b1;
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      p_rr    <= '0;
      p_ii    <= '0;
      p_ir    <= '0;
      p_ri    <= '0;
      p_br2   <= '0;
      p_bi2   <= '0;
      d_r     <= '0;
      neg_r   <= 1'b0;
      neg_i   <= 1'b0;
      sat_r   <= 1'b0;
      sat_i   <= 1'b0;
      dz_r    <= 1'b0;
      cnt     <= '0;
      C       <= '0;
      out_ovf <= 1'b0;
      out_dz  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && in_valid) begin
        a_r <= A;
        b_r <= B;
      end
      if (state == S_MUL) begin
        p_rr  <= pw'(ar) * pw'(br);
        p_ii  <= pw'(ai) * pw'(bi);
        p_ir  <= pw'(ai) * pw'(br);
        p_ri  <= pw'(ar) * pw'(bi);
        p_br2 <= pw'(br) * pw'(br);
        p_bi2 <= pw'(bi) * pw'(bi);
      end
      if (state == S_PREP) begin
        d_r   <= d_c;
        neg_r <= nr_c[nw-1];
        neg_i <= ni_c[nw-1];
        sat_r <= sat_r_c;
        sat_i <= sat_i_c;
        dz_r  <= dz_c;
        cnt   <= cnt_start;
      end
      if (state == S_DIV) cnt <= cnt - 1'b1;
      // Final quotient bit is taken from the divider's next value so C lands on DONE entry
      if (last) begin
        C       <= {res_r, res_i};
        out_ovf <= !dz_r && (sat_r || sat_i);
        out_dz  <= dz_r;
      end
    end
  end

  udiv_iter #(.dw(pw), .qw(qw)) u_div_r (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .step          (step),
    .dividend      (dvd_r),
    .divisor       (d_r),
    .quotient      (q_r),
    .quotient_next (qn_r)
  );

  udiv_iter #(.dw(pw), .qw(qw)) u_div_i (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .step          (step),
    .dividend      (dvd_i),
    .divisor       (d_r),
    .quotient      (q_i),
    .quotient_next (qn_i)
  );

endmodule

// File: tb/tb_cdiv.sv
// Self-checking bench for cdiv: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_cdiv;

  localparam int WS = 16;

  logic          clk;
  logic          reset;
  logic [31:0]   A, B, C;
  logic          in_valid, in_ready, out_valid, out_ready, out_ovf, out_dz;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int last_acc = 0;
  logic [33:0] last_res;

  cdiv #(.word_size(WS)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C         (C),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ovf   (out_ovf),
    .out_dz    (out_dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One component: saturate when |N| >= D, otherwise scaled fraction with sign of N.
  function automatic logic [16:0] comp(input longint n, input longint d);
    longint m, q;
    m = (n < 0) ? -n : n;
    if (m >= d) return {1'b1, (n < 0) ? 16'h8000 : 16'h7FFF};
    q = (m << (WS - 1)) / d;
    if (n < 0) q = -q;
    return {1'b0, q[15:0]};
  endfunction

  // Returns {dz, ovf, C}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    longint ar, ai, br, bi, nr, ni, d;
    logic [16:0] xr, xi;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    nr = ar * br + ai * bi;
    ni = ai * br - ar * bi;
    d  = br * br + bi * bi;
    if (d == 0) return {1'b1, 1'b0, 32'h7FFF7FFF};
    xr = comp(nr, d);
    xi = comp(ni, d);
    return {1'b0, xr[16] | xi[16], xr[15:0], xi[15:0]};
  endfunction

  // Called just after a negedge; returns just after a negedge with the block idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        input bit chk_space, input int exp_space);
    int n;
    int acc;
    logic [33:0] exp;
    exp       = model(a, b);
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    acc = edge_cnt;
    if (chk_space) chk("accept_spacing", 64'(acc - last_acc), 64'(exp_space));
    last_acc = acc;
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(edge_cnt - acc), 64'(WS + 1));
    chk("C", 64'(C), 64'(exp[31:0]));
    chk("ovf", 64'(out_ovf), 64'(exp[32]));
    chk("dz", 64'(out_dz), 64'(exp[33]));
    last_res = {out_dz, out_ovf, C};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result", 64'({out_dz, out_ovf, C}), 64'(exp));
      chk("hold_valid", 64'({out_valid, in_ready}), 64'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    int prev_hold;
    int hold;
    int seen;
    reset     = 1'b1;
    A         = '0;
    B         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out", 64'({out_dz, out_ovf, C}), 64'd0);
    chk("reset_hs", 64'({out_valid, in_ready}), 64'b01);

    run_op({16'h2000, 16'h2000}, {16'h4000, 16'h0000}, 0, 1'b0, 0);
    chk("basic_lit", 64'(last_res), 64'({2'b00, 32'h40004000}));
    run_op({16'h2000, 16'h0000}, {16'h0000, 16'h4000}, 0, 1'b1, WS + 3);
    chk("neg_imag_lit", 64'(last_res), 64'({2'b00, 32'h0000C000}));
    run_op({16'h4000, 16'h0000}, {16'h2000, 16'h0000}, 0, 1'b1, WS + 3);
    chk("sat_pos_lit", 64'(last_res), 64'({2'b01, 32'h7FFF0000}));
    run_op({16'hC000, 16'h0000}, {16'h2000, 16'h0000}, 5, 1'b1, WS + 3);
    chk("sat_neg_lit", 64'(last_res), 64'({2'b01, 32'h80000000}));
    run_op({16'h1234, 16'hABCD}, 32'h0, 0, 1'b1, WS + 3 + 5);
    chk("dz_lit", 64'(last_res), 64'({2'b10, 32'h7FFF7FFF}));

    // Abort mid-division: reset after the seventh divide step
    A        = {16'h2000, 16'h2000};
    B        = {16'h4000, 16'h0000};
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out", 64'({out_dz, out_ovf, C}), 64'd0);
    chk("abort_hs", 64'({out_valid, in_ready}), 64'b01);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    run_op({16'h1000, 16'hF000}, {16'h3000, 16'h1000}, 0, 1'b0, 0);

    prev_hold = 0;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 0) rb = {rb[31:16] | 16'h4000, rb[15:0] >> 4};
      hold = int'($urandom_range(0, 3));
      run_op(ra, rb, hold, 1'b1, WS + 3 + prev_hold);
      prev_hold = hold;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
